instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter BOOT_ADDR, default 32'h0000_0000, the PC fetched first after reset.
REQ-002 SHALL have parameter ROM_AW, default 14, the byte-address width of the instruction ROM port.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port o_rom_addr  output  ROM_AW  byte address presented to the instruction ROM.
REQ-006 SHALL have port i_rom_data  input  32  ROM read data, valid exactly one cycle after the address.
REQ-007 SHALL have port i_redirect  input  1  flush-and-jump request from execute.
REQ-008 SHALL have port i_redirect_pc  input  32  jump target, sampled when i_redirect=1.
REQ-009 SHALL have port o_instr_valid  output  1  instruction available to decode.
REQ-010 SHALL have port o_instr  output  32  instruction word.
REQ-011 SHALL have port o_instr_pc  output  32  PC of o_instr.
REQ-012 SHALL have port i_instr_ready  input  1  decode accepts; transfer when valid and ready are both 1.

Function
REQ-013 SHALL keep a fetch PC; o_rom_addr SHALL equal pc[ROM_AW-1:0] combinationally, with bits [1:0] forced to 0.
REQ-014 SHALL treat a ROM request as issued in a cycle when issue_en=1; the response SHALL be captured from i_rom_data on the following cycle only.
REQ-015 SHALL set issue_en=1 only if (buffer occupancy + in-flight count) < 2, guaranteeing no response is ever dropped.
REQ-016 SHALL advance pc by 4 after each issued request; 32-bit wrap from 32'hFFFF_FFFC to 0 is permitted; o_rom_addr wraps modulo 2^ROM_AW.
REQ-017 SHALL track one in-flight flag plus its PC; on the response cycle it SHALL push {i_rom_data, inflight_pc} into a 2-entry FIFO.
REQ-018 SHALL drive o_instr_valid = FIFO non-empty, and o_instr/o_instr_pc from the FIFO head.
REQ-019 SHALL pop the FIFO on valid and ready; push and pop in the same cycle SHALL both take effect, occupancy unchanged.
REQ-020 SHALL hold o_instr and o_instr_pc stable while o_instr_valid=1 and i_instr_ready=0.
REQ-021 SHALL, on i_redirect=1, in that same cycle clear the FIFO, mark any in-flight response as discard, and load pc with {i_redirect_pc[31:2],2'b00}.
REQ-022 SHALL drop a discarded response and not push it.
REQ-023 SHALL drive o_instr_valid=0 in the cycle after a redirect; the first post-redirect instruction SHALL be valid no earlier than two cycles after the redirect cycle.
REQ-024 SHALL give redirect priority over a simultaneous handshake or push; an instruction accepted in the redirect cycle counts as consumed.
REQ-025 SHALL issue no request in the redirect cycle.

Reset
REQ-026 SHALL, while rst_n=0, set pc=BOOT_ADDR, in-flight=0, FIFO empty, o_instr_valid=0, o_instr=0, o_instr_pc=0.
REQ-027 SHALL issue the first request in the first clock edge after rst_n deasserts.
REQ-028 SHALL ignore the ROM's reset-time output of 0 because no request is outstanding.
REQ-029 SHALL abandon all in-flight and buffered state on reset mid-operation, with no output on the first cycle after reset.

Structure
REQ-030 SHALL take the default BOOT_ADDR and ROM_AW, and the fetch-entry typedef {instr[31:0], pc[31:0]}, from a shared package, core_pkg.
REQ-031 SHALL implement the 2-entry buffer as a sub-module, fetch_fifo, with push/pop/flush/full/empty.

Verification
REQ-032 Bench SHALL cover reset release with ready=1 and the standard ROM image: o_rom_addr 0x0000, then 0x0004; the first valid is instr 0x12300013 at pc 0x0, then 0x45600013 at pc 0x4, one instruction per cycle.
REQ-033 Bench SHALL cover ready=0 for 5 cycles, then 1: at most 2 buffered, no issue while full, and the output sequence continues at pc 0x8 with no gaps or duplicates.
REQ-034 Bench SHALL cover redirect to 0x22 with the FIFO full: next valid is pc 0x20, instr 0x00306513, and no stale pc 0x8/0xC appears.
REQ-035 Bench SHALL cover redirect and handshake in the same cycle: the accepted instruction is counted once, and the next valid is the redirect target.
REQ-036 Bench SHALL cover pc 0x3FFC with ROM_AW=14: the next o_rom_addr is 0x0000 and o_instr_pc is 0x4000.
REQ-037 Bench SHALL cover rst_n asserted for 1 cycle mid-stream: outputs are zero immediately, then restart at BOOT_ADDR.

Source files
------------

// File: rtl/core_pkg.sv
// Shared fetch-path definitions: default boot/ROM geometry and the buffered
// instruction entry format used between the fetch unit and its buffer.
package core_pkg;

  localparam logic [31:0] BOOT_ADDR_DEFAULT = 32'h0000_0000;
  localparam int          ROM_AW_DEFAULT    = 14;
  localparam int          FETCH_DEPTH       = 2;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry fetch buffer; flush wins over push/pop, and a push into a full
// buffer is accepted only when the head is popped in the same cycle.
module fetch_fifo
  import core_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty
);

  logic [1:0]   count_reg, count_next;
  logic         rd_ptr_reg, wr_ptr_reg;
  logic         do_push, do_pop;
  fetch_entry_t slot [FETCH_DEPTH];

  assign empty   = (count_reg == 2'd0);
  assign full    = (count_reg == 2'(FETCH_DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = slot[rd_ptr_reg];

  // Single-bit pointers: the buffer is exactly two entries deep.
  genvar gi;
  generate
    for (gi = 0; gi < FETCH_DEPTH; gi++) begin : g_slot
      fetch_entry_t entry_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          entry_reg <= '0;
        end else if (do_push && !flush && (wr_ptr_reg == 1'(gi))) begin
          entry_reg <= din;
        end
      end
      assign slot[gi] = entry_reg;
    end
  endgenerate

  always_comb begin
    count_next = count_reg;
    if (do_push && !do_pop) begin
      count_next = count_reg + 2'd1;
    end else if (do_pop && !do_push) begin
      count_next = count_reg - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg  <= 2'd0;
      rd_ptr_reg <= 1'b0;
      wr_ptr_reg <= 1'b0;
    end else if (flush) begin
      count_reg  <= 2'd0;
      rd_ptr_reg <= 1'b0;
      wr_ptr_reg <= 1'b0;
    end else begin
      count_reg <= count_next;
      if (do_pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      if (do_push) begin
        wr_ptr_reg <= ~wr_ptr_reg;
      end
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: walks a word-aligned PC through a one-cycle-latency ROM,
// buffers responses in a two-entry FIFO and supports flush-and-jump redirects.
module instr_fetch
  import core_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR = BOOT_ADDR_DEFAULT,
  parameter int          ROM_AW    = ROM_AW_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ROM_AW-1:0] o_rom_addr,
  input  logic [31:0]       i_rom_data,
  input  logic              i_redirect,
  input  logic [31:0]       i_redirect_pc,
  output logic              o_instr_valid,
  output logic [31:0]       o_instr,
  output logic [31:0]       o_instr_pc,
  input  logic              i_instr_ready
);

  logic [31:0]  pc_reg, pc_next;
  logic [31:0]  inflight_pc_reg;
  logic         inflight_reg;
  logic         issue_en, pop_fire, push_en;
  logic         fifo_full, fifo_empty;
  logic [1:0]   occupancy;
  logic [2:0]   load;
  fetch_entry_t push_entry, head_entry;

  assign o_rom_addr    = {pc_reg[ROM_AW-1:2], 2'b00};
  assign o_instr_valid = !fifo_empty;
  assign o_instr       = head_entry.instr;
  assign o_instr_pc    = head_entry.pc;

  assign pop_fire   = o_instr_valid && i_instr_ready;
  // A response landing in a redirect cycle is stale; suppressing its push is
  // the discard, and no issue in that cycle leaves nothing else in flight.
  assign push_en    = inflight_reg && !i_redirect;
  assign push_entry = '{instr: i_rom_data, pc: inflight_pc_reg};

  // Occupancy is counted net of this cycle's pop so a steady stream can issue
  // every cycle while still leaving a slot for every outstanding response.
  assign occupancy = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);
  assign load      = {1'b0, occupancy} - {2'b00, pop_fire} + {2'b00, inflight_reg};
  assign issue_en  = !i_redirect && (load < 3'd2);

  always_comb begin
    pc_next = pc_reg;
    if (i_redirect) begin
      pc_next = align_word(i_redirect_pc);
    end else if (issue_en) begin
      pc_next = pc_reg + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg          <= align_word(BOOT_ADDR);
      inflight_reg    <= 1'b0;
      inflight_pc_reg <= '0;
    end else begin
      pc_reg       <= pc_next;
      inflight_reg <= issue_en;
      if (issue_en) begin
        inflight_pc_reg <= pc_reg;
      end
    end
  end

  fetch_fifo u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_en),
    .pop   (pop_fire),
    .flush (i_redirect),
    .din   (push_entry),
    .head  (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch: synchronous ROM model, an in-order stream
// model of accepted instructions, and directed boundary scenarios.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [13:0] o_rom_addr;
  logic [31:0] i_rom_data;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_instr_valid;
  logic [31:0] o_instr;
  logic [31:0] o_instr_pc;
  logic        i_instr_ready;

  int errors = 0;
  int checks = 0;

  // stream model state
  logic [31:0] exp_pc = 32'h0;
  int          n_acc = 0;
  bit          post_reset = 1'b0;
  bit          post_redirect = 1'b0;
  bit          prev_stall = 1'b0;
  bit          prev_hs = 1'b0;
  logic [31:0] prev_instr = 32'h0;
  logic [31:0] prev_pc = 32'h0;

  instr_fetch dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .o_rom_addr    (o_rom_addr),
    .i_rom_data    (i_rom_data),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_instr_valid (o_instr_valid),
    .o_instr       (o_instr),
    .o_instr_pc    (o_instr_pc),
    .i_instr_ready (i_instr_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [11:0] idx);
    case (idx)
      12'd0:   return 32'h1230_0013;
      12'd1:   return 32'h4560_0013;
      12'd8:   return 32'h0030_6513;
      default: return {8'hA5, 4'h0, idx, 8'h13};
    endcase
  endfunction

  function automatic logic [31:0] instr_at(input logic [31:0] pc);
    return rom_word(pc[13:2]);
  endfunction

  // ROM: data for the presented address appears one cycle later, 0 in reset
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) i_rom_data <= 32'h0;
    else        i_rom_data <= rom_word(o_rom_addr[13:2]);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle compare against the stream model
  always @(negedge clk) begin
    if (!rst_n) begin
      check("reset_valid", {31'b0, o_instr_valid}, 32'd0);
      check("reset_instr", o_instr, 32'h0);
      check("reset_pc", o_instr_pc, 32'h0);
      exp_pc        = 32'h0;
      post_reset    = 1'b1;
      post_redirect = 1'b0;
      prev_stall    = 1'b0;
      prev_hs       = 1'b0;
    end else begin
      if (post_reset) check("post_reset_idle", {31'b0, o_instr_valid}, 32'd0);
      if (post_redirect) check("post_redirect_idle", {31'b0, o_instr_valid}, 32'd0);
      if (prev_stall) begin
        check("hold_valid", {31'b0, o_instr_valid}, 32'd1);
        check("hold_instr", o_instr, prev_instr);
        check("hold_pc", o_instr_pc, prev_pc);
      end
      if (prev_hs && i_instr_ready) check("no_gap", {31'b0, o_instr_valid}, 32'd1);
      post_reset    = 1'b0;
      post_redirect = 1'b0;
      if (o_instr_valid && i_instr_ready) begin
        check("stream_pc", o_instr_pc, exp_pc);
        check("stream_instr", o_instr, instr_at(exp_pc));
        $display("accept pc=0x%08h instr=0x%08h redirect=%0d", o_instr_pc, o_instr, i_redirect);
        exp_pc = exp_pc + 32'd4;
        n_acc++;
      end
      prev_hs    = o_instr_valid && i_instr_ready && !i_redirect;
      prev_stall = o_instr_valid && !i_instr_ready && !i_redirect;
      prev_instr = o_instr;
      prev_pc    = o_instr_pc;
      if (i_redirect) begin
        exp_pc        = {i_redirect_pc[31:2], 2'b00};
        post_redirect = 1'b1;
        $display("redirect target=0x%08h", i_redirect_pc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n = 0;
    @(negedge clk);
    while (!o_instr_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'b0, o_instr_valid}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    rst_n = 1'b0;
    i_instr_ready = 1'b1;
    i_redirect = 1'b0;
    i_redirect_pc = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_rom_addr", {18'b0, o_rom_addr}, 32'h0);

    // reset release, standard image, one instruction per cycle
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("boot_addr0", {18'b0, o_rom_addr}, 32'h0000);
    @(negedge clk);
    check("boot_addr1", {18'b0, o_rom_addr}, 32'h0004);
    @(negedge clk);
    check("first_valid", {31'b0, o_instr_valid}, 32'd1);
    check("first_pc", o_instr_pc, 32'h0);
    check("first_instr", o_instr, 32'h1230_0013);
    @(negedge clk);
    check("second_pc", o_instr_pc, 32'h4);
    check("second_instr", o_instr, 32'h4560_0013);

    // decode stalls 5 cycles: buffer fills, issue stops, stream resumes at 0x8
    step();
    i_instr_ready = 1'b0;
    repeat (5) @(negedge clk);
    check("stall_head_pc", o_instr_pc, 32'h8);
    check("stall_no_issue", {18'b0, o_rom_addr}, 32'h0010);
    step();
    i_instr_ready = 1'b1;
    @(negedge clk);
    check("resume_pc0", o_instr_pc, 32'h8);
    @(negedge clk);
    check("resume_pc1", o_instr_pc, 32'hC);
    @(negedge clk);
    check("resume_pc2", o_instr_pc, 32'h10);

    // redirect to 0x22 while the buffer is full
    step();
    i_instr_ready = 1'b0;
    repeat (4) step();
    i_redirect = 1'b1;
    i_redirect_pc = 32'h22;
    step();
    i_redirect = 1'b0;
    i_instr_ready = 1'b1;
    wait_valid("redir_full_timeout", 8);
    check("redir_full_pc", o_instr_pc, 32'h20);
    check("redir_full_instr", o_instr, 32'h0030_6513);

    // redirect in the same cycle as a handshake on 0x24
    step();
    snap = n_acc;
    i_redirect = 1'b1;
    i_redirect_pc = 32'h100;
    @(negedge clk);
    check("redir_hs_pc", o_instr_pc, 32'h24);
    step();
    i_redirect = 1'b0;
    wait_valid("redir_hs_timeout", 8);
    check("redir_hs_target", o_instr_pc, 32'h100);
    #1;
    check("redir_hs_count", n_acc, snap + 2);

    // ROM address wrap at the top of the 14-bit space
    step();
    i_redirect = 1'b1;
    i_redirect_pc = 32'h3FFC;
    step();
    i_redirect = 1'b0;
    @(negedge clk);
    check("wrap_addr0", {18'b0, o_rom_addr}, 32'h3FFC);
    @(negedge clk);
    check("wrap_addr1", {18'b0, o_rom_addr}, 32'h0000);
    wait_valid("wrap_timeout", 8);
    check("wrap_pc0", o_instr_pc, 32'h3FFC);
    @(negedge clk);
    check("wrap_pc1", o_instr_pc, 32'h4000);
    check("wrap_instr1", o_instr, 32'h1230_0013);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step();
      i_instr_ready = ($urandom_range(0, 3) != 0);
      i_redirect    = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 2))
        0:       i_redirect_pc = $urandom_range(0, 32'h3FFF);
        1:       i_redirect_pc = $urandom;
        default: i_redirect_pc = 32'hFFFF_FFF0 + $urandom_range(0, 15);
      endcase
    end
    step();
    i_redirect = 1'b0;
    i_instr_ready = 1'b1;
    repeat (6) step();

    // one-cycle reset mid-stream
    rst_n = 1'b0;
    #1;
    check("midrst_valid", {31'b0, o_instr_valid}, 32'd0);
    check("midrst_instr", o_instr, 32'h0);
    check("midrst_pc", o_instr_pc, 32'h0);
    step();
    rst_n = 1'b1;
    wait_valid("restart_timeout", 8);
    check("restart_pc", o_instr_pc, 32'h0);
    check("restart_instr", o_instr, 32'h1230_0013);

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
